// File: rtl/serial_add2.sv
// serial_add2 -- ready/valid serial adder that folds two bits per clock.
// Operands A, B and carry-in CI are captured on the accepting edge, then
// WIDTH/2 clocks of a 2-bit full-adder slice build the sum LSB-first.
// The result (S, CO) is presented from registers until the consumer takes it.
// WIDTH must be even and >= 2.
// Build option: define SERIAL_ADD2_OVF_EN to add the OV (signed overflow) output.
module serial_add2 #(
   parameter int WIDTH = 8
) (
   input  logic             CK,
   input  logic             RN,
   input  logic             IVALID,
   output logic             IREADY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CI,
   output logic             OVALID,
   input  logic             OREADY,
   output logic [WIDTH-1:0] S,
`ifdef SERIAL_ADD2_OVF_EN
   output logic             OV,
`endif
   output logic             CO
);

   localparam int DIGITS = WIDTH / 2;
   localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cy_q, cy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rdy_q;
   logic             vld_q;
`ifdef SERIAL_ADD2_OVF_EN
   logic             ov_q, ov_d;
`endif

   // 2-bit slice signals for the digit currently at the bottom of A/B
   logic             s0, s1, c0, c1;
   logic [WIDTH+1:0] sum_ext;
   logic             accept;
   logic             last_digit;

   function automatic logic maj(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   // Next-state and datapath: one 2-bit full-adder digit per RUN cycle
   always_comb begin
      c0         = maj(a_q[0], b_q[0], cy_q);
      s0         = a_q[0] ^ b_q[0] ^ cy_q;
      c1         = maj(a_q[1], b_q[1], c0);
      s1         = a_q[1] ^ b_q[1] ^ c0;
      // new digit enters at the top, older digits move down by two
      sum_ext    = {s1, s0, sum_q};
      accept     = IVALID & rdy_q;
      last_digit = (cnt_q == CNT_W'(DIGITS - 1));

      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      sum_d      = sum_q;
      cy_d       = cy_q;
      cnt_d      = cnt_q;
`ifdef SERIAL_ADD2_OVF_EN
      ov_d       = ov_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               a_d     = A;
               b_d     = B;
               cy_d    = CI;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_d   = a_q >> 2;
            b_d   = b_q >> 2;
            sum_d = sum_ext[WIDTH+1:2];
            cy_d  = c1;
`ifdef SERIAL_ADD2_OVF_EN
            // carry into vs. out of the MSB; the last digit's value is kept
            ov_d  = c0 ^ c1;
`endif
            cnt_d = cnt_q + CNT_W'(1);
            if (last_digit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // result held; new operands are not looked at until IDLE
            if (OREADY) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake flags; reset aborts any operation
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cy_q    <= 1'b0;
         cnt_q   <= '0;
         rdy_q   <= 1'b0;
         vld_q   <= 1'b0;
`ifdef SERIAL_ADD2_OVF_EN
         ov_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cy_q    <= cy_d;
         cnt_q   <= cnt_d;
         // flags follow the next state so they are pure flop outputs;
         // IREADY stays low until the first edge after reset release
         rdy_q   <= (state_d == ST_IDLE);
         vld_q   <= (state_d == ST_DONE);
`ifdef SERIAL_ADD2_OVF_EN
         ov_q    <= ov_d;
`endif
      end
   end

   assign IREADY = rdy_q;
   assign OVALID = vld_q;
   assign S      = sum_q;
   assign CO     = cy_q;
`ifdef SERIAL_ADD2_OVF_EN
   assign OV     = ov_q;
`endif

endmodule
